lk_flow_solver: RTL and testbench

- Per-pixel Lucas-Kanade solve stage. Sits directly downstream of the 5x5 window accumulator.
- Consumes the five structure-tensor sums plus pixel coordinates at up to one pixel per clock.
- Solves the 2x2 system for the flow vector (u,v) in signed fixed point.
- Fully pipelined: multiply stage, determinant stage, sign/magnitude stage, then a staged restoring divider.

---
 rtl/lk_flow_solver.sv | 198 +++++++++++++++++++
 tb/tb_lk_flow_solver.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lk_flow_solver.sv
// Lucas-Kanade 2x2 solve: windowed structure-tensor sums in, signed fixed-point flow (u,v) out.
// Stages: products, determinant/numerators, sign/magnitude, restoring divider, saturate/sign.
module lk_flow_solver #(
    parameter int unsigned ACCUM_WIDTH = 32,
    parameter int unsigned FLOW_WIDTH  = 16,
    parameter int unsigned FRAC_BITS   = 8,
    parameter longint      DET_MIN     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [ACCUM_WIDTH-1:0] sum_IxIx,
    input  logic signed [ACCUM_WIDTH-1:0] sum_IyIy,
    input  logic signed [ACCUM_WIDTH-1:0] sum_IxIy,
    input  logic signed [ACCUM_WIDTH-1:0] sum_IxIt,
    input  logic signed [ACCUM_WIDTH-1:0] sum_IyIt,
    input  logic                          accum_valid,
    input  logic [9:0]                    accum_x_coord,
    input  logic [8:0]                    accum_y_coord,
    output logic signed [FLOW_WIDTH-1:0]  flow_u,
    output logic signed [FLOW_WIDTH-1:0]  flow_v,
    output logic [9:0]                    flow_x_coord,
    output logic [8:0]                    flow_y_coord,
    output logic                          flow_reliable,
    output logic                          flow_valid,
    output logic [31:0]                   unreliable_count,
    input  logic                          clear_stats
);
    localparam int unsigned PW = 2 * ACCUM_WIDTH;
    localparam int unsigned DW = PW + 1;
    localparam int unsigned CW = DW + FRAC_BITS + FLOW_WIDTH;
    localparam int unsigned NS = FLOW_WIDTH - 1;
    localparam int unsigned QW = FLOW_WIDTH - 1;

    logic                 s1_vld_q, s2_vld_q;
    logic signed [PW-1:0] p_xxyy_q, p_xyxy_q, p_xyyt_q, p_yyxt_q, p_xyxt_q, p_xxyt_q;
    logic [9:0]           s1_x_q, s2_x_q;
    logic [8:0]           s1_y_q, s2_y_q;
    logic signed [DW-1:0] det_q, num_u_q, num_v_q;

    // Divider pipeline; index 0 is the sign/magnitude stage, index NS the last quotient bit.
    logic [NS:0]   vld_q;
    logic [CW-1:0] rem_u_q [0:NS];
    logic [CW-1:0] rem_v_q [0:NS];
    logic [QW-1:0] quo_u_q [0:NS];
    logic [QW-1:0] quo_v_q [0:NS];
    logic [PW-1:0] dsr_q   [0:NS];
    logic          neg_u_q [0:NS];
    logic          neg_v_q [0:NS];
    logic          ovf_u_q [0:NS];
    logic          ovf_v_q [0:NS];
    logic          rel_q   [0:NS];
    logic [9:0]    x_q     [0:NS];
    logic [8:0]    y_q     [0:NS];

    logic          rel_d, neg_u_d, neg_v_d, ovf_u_d, ovf_v_d;
    logic [DW-1:0] mag_u_d, mag_v_d;
    logic [CW-1:0] dvd_u_d, dvd_v_d, lim_d;

    always_comb begin
        rel_d   = det_q > DW'(DET_MIN);
        mag_u_d = num_u_q[DW-1] ? -num_u_q : num_u_q;
        mag_v_d = num_v_q[DW-1] ? -num_v_q : num_v_q;
        neg_u_d = rel_d & num_u_q[DW-1];
        neg_v_d = rel_d & num_v_q[DW-1];
        if (!rel_d) begin
            mag_u_d = '0;
            mag_v_d = '0;
        end
        dvd_u_d = CW'(mag_u_d) << FRAC_BITS;
        dvd_v_d = CW'(mag_v_d) << FRAC_BITS;
        // Quotient would not fit in FLOW_WIDTH-1 magnitude bits.
        lim_d   = CW'(det_q[PW-1:0]) << (FLOW_WIDTH - 1);
        ovf_u_d = dvd_u_d >= lim_d;
        ovf_v_d = dvd_v_d >= lim_d;
    end

    logic [CW-1:0] rem_u_d [0:NS-1];
    logic [CW-1:0] rem_v_d [0:NS-1];
    logic [QW-1:0] quo_u_d [0:NS-1];
    logic [QW-1:0] quo_v_d [0:NS-1];
    logic [CW-1:0] trial;

    always_comb begin
        trial = '0;
        for (int i = 0; i < NS; i++) begin
            trial      = CW'(dsr_q[i]) << (QW - 1 - i);
            rem_u_d[i] = rem_u_q[i];
            rem_v_d[i] = rem_v_q[i];
            quo_u_d[i] = quo_u_q[i];
            quo_v_d[i] = quo_v_q[i];
            if (rem_u_q[i] >= trial) begin
                rem_u_d[i] = rem_u_q[i] - trial;
                quo_u_d[i] = quo_u_q[i] | (QW'(1) << (QW - 1 - i));
            end
            if (rem_v_q[i] >= trial) begin
                rem_v_d[i] = rem_v_q[i] - trial;
                quo_v_d[i] = quo_v_q[i] | (QW'(1) << (QW - 1 - i));
            end
        end
    end

    logic [QW-1:0]               mag_o_u, mag_o_v;
    logic signed [FLOW_WIDTH-1:0] res_u_d, res_v_d;

    always_comb begin
        mag_o_u = ovf_u_q[NS] ? {QW{1'b1}} : quo_u_q[NS];
        mag_o_v = ovf_v_q[NS] ? {QW{1'b1}} : quo_v_q[NS];
        res_u_d = neg_u_q[NS] ? -$signed({1'b0, mag_o_u}) : $signed({1'b0, mag_o_u});
        res_v_d = neg_v_q[NS] ? -$signed({1'b0, mag_o_v}) : $signed({1'b0, mag_o_v});
        if (!rel_q[NS]) begin
            res_u_d = '0;
            res_v_d = '0;
        end
    end

    // Data path carries no reset; only valid bits and outputs are cleared.
    always_ff @(posedge clk) begin
        p_xxyy_q <= PW'(sum_IxIx) * PW'(sum_IyIy);
        p_xyxy_q <= PW'(sum_IxIy) * PW'(sum_IxIy);
        p_xyyt_q <= PW'(sum_IxIy) * PW'(sum_IyIt);
        p_yyxt_q <= PW'(sum_IyIy) * PW'(sum_IxIt);
        p_xyxt_q <= PW'(sum_IxIy) * PW'(sum_IxIt);
        p_xxyt_q <= PW'(sum_IxIx) * PW'(sum_IyIt);
        s1_x_q   <= accum_x_coord;
        s1_y_q   <= accum_y_coord;

        det_q    <= DW'(p_xxyy_q) - DW'(p_xyxy_q);
        num_u_q  <= DW'(p_xyyt_q) - DW'(p_yyxt_q);
        num_v_q  <= DW'(p_xyxt_q) - DW'(p_xxyt_q);
        s2_x_q   <= s1_x_q;
        s2_y_q   <= s1_y_q;

        rem_u_q[0] <= dvd_u_d;
        rem_v_q[0] <= dvd_v_d;
        quo_u_q[0] <= '0;
        quo_v_q[0] <= '0;
        dsr_q[0]   <= det_q[PW-1:0];
        neg_u_q[0] <= neg_u_d;
        neg_v_q[0] <= neg_v_d;
        ovf_u_q[0] <= ovf_u_d;
        ovf_v_q[0] <= ovf_v_d;
        rel_q[0]   <= rel_d;
        x_q[0]     <= s2_x_q;
        y_q[0]     <= s2_y_q;

        for (int i = 0; i < NS; i++) begin
            rem_u_q[i+1] <= rem_u_d[i];
            rem_v_q[i+1] <= rem_v_d[i];
            quo_u_q[i+1] <= quo_u_d[i];
            quo_v_q[i+1] <= quo_v_d[i];
            dsr_q[i+1]   <= dsr_q[i];
            neg_u_q[i+1] <= neg_u_q[i];
            neg_v_q[i+1] <= neg_v_q[i];
            ovf_u_q[i+1] <= ovf_u_q[i];
            ovf_v_q[i+1] <= ovf_v_q[i];
            rel_q[i+1]   <= rel_q[i];
            x_q[i+1]     <= x_q[i];
            y_q[i+1]     <= y_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q      <= 1'b0;
            s2_vld_q      <= 1'b0;
            vld_q         <= '0;
            flow_valid    <= 1'b0;
            flow_u        <= '0;
            flow_v        <= '0;
            flow_x_coord  <= '0;
            flow_y_coord  <= '0;
            flow_reliable <= 1'b0;
        end else begin
            s1_vld_q   <= accum_valid;
            s2_vld_q   <= s1_vld_q;
            vld_q      <= {vld_q[NS-1:0], s2_vld_q};
            flow_valid <= vld_q[NS];
            if (vld_q[NS]) begin
                flow_u        <= res_u_d;
                flow_v        <= res_v_d;
                flow_x_coord  <= x_q[NS];
                flow_y_coord  <= y_q[NS];
                flow_reliable <= rel_q[NS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unreliable_count <= '0;
        end else if (clear_stats) begin
            unreliable_count <= '0;
        end else if (flow_valid && !flow_reliable && unreliable_count != '1) begin
            unreliable_count <= unreliable_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_lk_flow_solver.sv
// Self-checking bench for lk_flow_solver: directed solves, random streams vs. an arithmetic model,
// mid-stream reset and statistics clear.
module tb_lk_flow_solver;
    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] s_xx, s_yy, s_xy, s_xt, s_yt;
    logic               accum_valid, clear_stats;
    logic [9:0]         ax, fx;
    logic [8:0]         ay, fy;
    logic signed [15:0] fu, fv;
    logic               frel, fvld;
    logic [31:0]        ucnt;

    always #5 clk = ~clk;

    lk_flow_solver dut (
        .clk             (clk),
        .rst             (rst),
        .sum_IxIx        (s_xx),
        .sum_IyIy        (s_yy),
        .sum_IxIy        (s_xy),
        .sum_IxIt        (s_xt),
        .sum_IyIt        (s_yt),
        .accum_valid     (accum_valid),
        .accum_x_coord   (ax),
        .accum_y_coord   (ay),
        .flow_u          (fu),
        .flow_v          (fv),
        .flow_x_coord    (fx),
        .flow_y_coord    (fy),
        .flow_reliable   (frel),
        .flow_valid      (fvld),
        .unreliable_count(ucnt),
        .clear_stats     (clear_stats)
    );

    typedef struct {
        logic signed [15:0] u;
        logic signed [15:0] v;
        logic [9:0]         x;
        logic [8:0]         y;
        logic               rel;
        int                 cyc;
    } item_t;

    item_t exp_q[$];
    item_t obs_q[$];
    item_t col;
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    exp_unrel = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (fvld === 1'b1) begin
            col.u   = fu;
            col.v   = fv;
            col.x   = fx;
            col.y   = fy;
            col.rel = frel;
            col.cyc = cyc;
            obs_q.push_back(col);
        end
    end

    // Closed-form solve in wide arithmetic: q = (|num| * 2^8) / det, clamp to 32767, truncate.
    function automatic item_t model(input logic signed [31:0] xx, yy, xy, xt, yt);
        logic signed [127:0] a, b, c, d, e, det, nu, nv, mu, mv;
        logic [127:0]        qu, qv;
        item_t               it;
        a = 128'(xx); b = 128'(yy); c = 128'(xy); d = 128'(xt); e = 128'(yt);
        det = a * b - c * c;
        nu  = c * e - b * d;
        nv  = c * d - a * e;
        it.rel = det > 128'sd0;
        it.u = '0; it.v = '0; it.x = '0; it.y = '0; it.cyc = 0;
        if (it.rel) begin
            mu = (nu < 128'sd0) ? -nu : nu;
            mv = (nv < 128'sd0) ? -nv : nv;
            qu = 128'(mu <<< 8) / 128'(det);
            qv = 128'(mv <<< 8) / 128'(det);
            if (qu > 128'd32767) qu = 128'd32767;
            if (qv > 128'd32767) qv = 128'd32767;
            it.u = (nu < 128'sd0) ? -16'(qu) : 16'(qu);
            it.v = (nv < 128'sd0) ? -16'(qv) : 16'(qv);
        end
        return it;
    endfunction

    function automatic logic signed [31:0] rnd(input int sh);
        logic signed [31:0] r;
        r = $urandom;
        return r >>> sh;
    endfunction

    task automatic send(input logic signed [31:0] xx, yy, xy, xt, yt,
                        input logic [9:0] x, input logic [8:0] y);
        item_t it;
        @(posedge clk); #1;
        s_xx = xx; s_yy = yy; s_xy = xy; s_xt = xt; s_yt = yt;
        ax = x; ay = y; accum_valid = 1'b1;
        it = model(xx, yy, xy, xt, yt);
        it.x = x; it.y = y; it.cyc = cyc;
        exp_q.push_back(it);
        if (!it.rel) exp_unrel++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            accum_valid = 1'b0;
            s_xx = $urandom; s_yy = $urandom; s_xy = $urandom; s_xt = $urandom; s_yt = $urandom;
            ax = 10'($urandom); ay = 9'($urandom);
        end
    endtask

    task automatic send_rand();
        int sh, sh2;
        logic signed [31:0] xx, yy;
        case ($urandom_range(0, 3))
            0:       sh = 24;
            1:       sh = 16;
            2:       sh = 8;
            default: sh = 0;
        endcase
        xx = rnd(sh);
        yy = rnd(sh);
        if (xx < 0) xx = -xx;
        if (yy < 0) yy = -yy;
        sh2 = sh + int'($urandom_range(0, 6));
        if (sh2 > 31) sh2 = 31;
        send(xx, yy, rnd(sh2), rnd(sh2), rnd(sh2), 10'($urandom), 9'($urandom));
    endtask

    task automatic wait_obs(input int n, output bit ok);
        int k = 0;
        while (obs_q.size() < n && k < 400) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #2;
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({fvld, frel, fu, fv, fx, fy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b r=%b u=%0d v=%0d x=%0d y=%0d expected all 0",
                     fvld, frel, fu, fv, fx, fy);
        end
        n_cmp++;
        if (ucnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_count got %0d expected 0", ucnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(25);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_spurious got %0d results expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_directed();
        int    tv [6][5] = '{'{4, 4, 0, -8, 4}, '{1, 1, 1, 5, 7}, '{3, 3, 0, -1, 0},
                             '{3, 3, 0, 1, 0}, '{1, 1, 0, -1000, 0}, '{1, 1, 0, 1000, 0}};
        int    eu [6] = '{512, 0, 85, -85, 32767, -32767};
        int    ev [6] = '{-256, 0, 0, 0, 0, 0};
        bit    er [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bit    ok;
        item_t e, o;
        for (int i = 0; i < 6; i++) begin
            send(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], 10'(100 + i), 9'(50 + i));
            idle(3);
        end
        wait_obs(6, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL dir_count got %0d expected 6", obs_q.size());
        end
        for (int i = 0; i < 6 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp += 4;
            if (o.u !== 16'(eu[i])) begin
                n_err++;
                $display("FAIL dir[%0d] u got %0d expected %0d", i, o.u, eu[i]);
            end
            if (o.v !== 16'(ev[i])) begin
                n_err++;
                $display("FAIL dir[%0d] v got %0d expected %0d", i, o.v, ev[i]);
            end
            if (o.rel !== er[i] || o.x !== e.x || o.y !== e.y) begin
                n_err++;
                $display("FAIL dir[%0d] rel/x/y got %b/%0d/%0d expected %b/%0d/%0d",
                         i, o.rel, o.x, o.y, er[i], e.x, e.y);
            end
            if (o.cyc - e.cyc != 19) begin
                n_err++;
                $display("FAIL dir[%0d] latency got %0d expected 19", i, o.cyc - e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
        idle(4);
        n_cmp++;
        if (fvld !== 1'b0 || fu !== 16'sh8001 || fx !== 10'd105) begin
            n_err++;
            $display("FAIL dir_hold got valid=%b u=%0d x=%0d expected 0/-32767/105", fvld, fu, fx);
        end
        n_cmp++;
        if (ucnt !== 32'd1) begin
            n_err++;
            $display("FAIL dir_unrel_count got %0d expected 1", ucnt);
        end
    endtask

    task automatic test_back_to_back();
        int    n, idx;
        bit    ok;
        item_t e, o;
        for (int i = 0; i < 320; i++) send_rand();
        idle(1);
        n = exp_q.size();
        wait_obs(n, ok);
        n_cmp++;
        if (!ok || obs_q.size() != n) begin
            n_err++;
            $display("FAIL b2b_count got %0d expected %0d", obs_q.size(), n);
        end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if ({o.u, o.v, o.rel, o.x, o.y} !== {e.u, e.v, e.rel, e.x, e.y} || o.cyc - e.cyc != 19)
            begin
                n_err++;
                $display("FAIL b2b[%0d] got u=%0d v=%0d r=%b x=%0d y=%0d lat=%0d expected u=%0d v=%0d r=%b x=%0d y=%0d lat=19",
                         idx, o.u, o.v, o.rel, o.x, o.y, o.cyc - e.cyc, e.u, e.v, e.rel, e.x, e.y);
            end
            idx++;
        end
        exp_q.delete();
        obs_q.delete();
        n_cmp++;
        if (ucnt !== 32'(exp_unrel)) begin
            n_err++;
            $display("FAIL b2b_unrel_count got %0d expected %0d", ucnt, exp_unrel);
        end
    endtask

    task automatic test_gapped();
        int    n, idx;
        bit    ok;
        item_t e, o;
        for (int i = 0; i < 60; i++) begin
            send_rand();
            idle($urandom_range(0, 3));
        end
        idle(1);
        n = exp_q.size();
        wait_obs(n, ok);
        n_cmp++;
        if (!ok || obs_q.size() != n) begin
            n_err++;
            $display("FAIL gap_count got %0d expected %0d", obs_q.size(), n);
        end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if ({o.u, o.v, o.rel, o.x, o.y} !== {e.u, e.v, e.rel, e.x, e.y} || o.cyc - e.cyc != 19)
            begin
                n_err++;
                $display("FAIL gap[%0d] got u=%0d v=%0d r=%b x=%0d y=%0d lat=%0d expected u=%0d v=%0d r=%b x=%0d y=%0d lat=19",
                         idx, o.u, o.v, o.rel, o.x, o.y, o.cyc - e.cyc, e.u, e.v, e.rel, e.x, e.y);
            end
            idx++;
        end
        exp_q.delete();
        obs_q.delete();
        n_cmp++;
        if (ucnt !== 32'(exp_unrel)) begin
            n_err++;
            $display("FAIL gap_unrel_count got %0d expected %0d", ucnt, exp_unrel);
        end
    endtask

    task automatic test_reset_midstream();
        bit    ok;
        item_t e, o;
        for (int i = 0; i < 10; i++) send_rand();
        @(posedge clk); #1;
        accum_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_unrel = 0;
        idle(40);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL midrst_flush got %0d results expected 0", obs_q.size());
        end
        n_cmp++;
        if (ucnt !== 32'd0) begin
            n_err++;
            $display("FAIL midrst_count got %0d expected 0", ucnt);
        end
        obs_q.delete();
        send(4, 4, 0, -8, 4, 10'd777, 9'd333);
        idle(1);
        wait_obs(1, ok);
        n_cmp++;
        if (!ok || obs_q.size() != 1) begin
            n_err++;
            $display("FAIL midrst_after got %0d results expected 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.u !== 16'sd512 || o.v !== -16'sd256 || o.x !== 10'd777 || o.y !== 9'd333 ||
                o.cyc - e.cyc != 19) begin
                n_err++;
                $display("FAIL midrst_pixel got u=%0d v=%0d x=%0d y=%0d lat=%0d expected 512/-256/777/333/19",
                         o.u, o.v, o.x, o.y, o.cyc - e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_clear_stats();
        bit ok, seen;
        send(1, 1, 1, 5, 7, 10'd1, 9'd1);
        idle(1);
        wait_obs(1, ok);
        n_cmp++;
        if (!ok || ucnt !== 32'd1) begin
            n_err++;
            $display("FAIL clr_pre got %0d expected 1", ucnt);
        end
        obs_q.delete();
        exp_q.delete();
        send(1, 1, 1, 5, 7, 10'd2, 9'd2);
        idle(1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #2;
            seen = (fvld === 1'b1);
        end
        n_cmp++;
        if (!seen || frel !== 1'b0) begin
            n_err++;
            $display("FAIL clr_result got seen=%b rel=%b expected 1/0", seen, frel);
        end
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        n_cmp++;
        if (ucnt !== 32'd0) begin
            n_err++;
            $display("FAIL clr_wins got %0d expected 0", ucnt);
        end
        obs_q.delete();
        exp_q.delete();
        send(1, 1, 1, 5, 7, 10'd3, 9'd3);
        idle(1);
        wait_obs(1, ok);
        n_cmp++;
        if (!ok || ucnt !== 32'd1) begin
            n_err++;
            $display("FAIL clr_post got %0d expected 1", ucnt);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        accum_valid = 1'b0;
        clear_stats = 1'b0;
        s_xx = '0; s_yy = '0; s_xy = '0; s_xt = '0; s_yt = '0;
        ax = '0; ay = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_gapped();
        test_reset_midstream();
        test_clear_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
